// File: rtl/count_chk_pkg.sv
// Shared types and default constants for the counter-pattern checker.
package count_chk_pkg;

  // Checker FSM states. The encoding is fixed so a debug probe can decode it.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Default parameter values.
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_MAX_MISS = 2;
  localparam int DEF_ERR_W    = 8;

  // Width of the match and miss run counters. LOCK_CNT and MAX_MISS are
  // limited to 1..15, so four bits is always enough.
  localparam int RUN_W = 4;

  // Value that the next sample must carry to count as an in-sequence
  // increment. The sum wraps modulo 2^w.
  function automatic logic [31:0] next_expected(input logic [31:0] v, input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. When clr and inc arrive in
// the same cycle the result is 1, so the event that coincides with the clear
// is still recorded.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] ZERO = '0;
  localparam logic [W-1:0] MAX  = '1;

  // Count register: clear has priority but keeps a coincident increment,
  // and the count sticks at all-ones once it gets there.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= ZERO;
    end else if (clr) begin
      count <= inc ? ONE : ZERO;
    end else if (inc && (count != MAX)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/count_seq_checker.sv
// Receive-side monitor for a free-running counter pattern. Each enabled
// sample must equal the previous sample plus one (wrapping). After LOCK_CNT
// good increments in a row the checker locks. While locked, every miss is
// counted, and MAX_MISS misses in a row drop back to acquisition.
//
// en is a plain qualifier, not a handshake: a sample is consumed on every
// rising clk where en=1, and with en=0 nothing moves except clear.
module count_seq_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int MAX_MISS = DEF_MAX_MISS,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] prev_val,
  output state_t           state
);

  localparam logic [RUN_W-1:0] LOCK_TGT = RUN_W'(LOCK_CNT);
  localparam logic [RUN_W-1:0] MISS_TGT = RUN_W'(MAX_MISS);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

  state_t           state_q, state_d;
  logic [RUN_W-1:0] match_q, match_d;
  logic [RUN_W-1:0] miss_q,  miss_d;
  logic [WIDTH-1:0] prev_q;
  logic             locked_q;
  logic             pulse_q;
  logic             err_inc;
  logic             is_match;
  logic [WIDTH-1:0] expect_val;
  logic [RUN_W-1:0] match_inc;
  logic [RUN_W-1:0] miss_inc;

  // The sample that keeps the sequence going, wrapping modulo 2^WIDTH.
  assign expect_val = WIDTH'(next_expected(32'(prev_q), WIDTH));
  assign is_match   = (din == expect_val);
  assign match_inc  = match_q + RUN_ONE;
  assign miss_inc   = miss_q + RUN_ONE;

  // Next-state logic: no comparison in IDLE, run counting in ACQ, and
  // error/miss accounting in LOCKED. Nothing advances without en.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_inc = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          // First sample after reset only seeds prev_val.
          state_d = ACQ;
          match_d = '0;
          miss_d  = '0;
        end
        ACQ: begin
          if (is_match) begin
            if (match_inc == LOCK_TGT) begin
              state_d = LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (is_match) begin
            miss_d = '0;
          end else begin
            err_inc = 1'b1;
            if (miss_inc == MISS_TGT) begin
              state_d = ACQ;
              match_d = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: begin
          state_d = IDLE;
          match_d = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  // FSM and run-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      match_q <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      miss_q  <= miss_d;
    end
  end

  // Registered outputs: locked follows the next state so it falls on the
  // same edge that raises the pulse for the final miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      if (en) begin
        prev_q <= din;
      end
      locked_q <= (state_d == LOCKED);
      pulse_q  <= err_inc;
    end
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .clr   (clear),
    .count (err_count)
  );

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign prev_val  = prev_q;
  assign state     = state_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker. A second instance with a 2-bit error counter
// shares the stimulus so saturation can be seen directly.
module tb_count_seq_checker;
  import count_chk_pkg::*;

  localparam int W1 = 20; // {locked, err_pulse, err_count[7:0], prev_val[7:0], state[1:0]}
  localparam int W2 = 14; // {locked, err_pulse, err_count[1:0], prev_val[7:0], state[1:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] din = 8'h00;

  logic       locked, err_pulse;
  logic [7:0] err_count, prev_val;
  state_t     state;

  logic       locked2, err_pulse2;
  logic [1:0] err_count2;
  logic [7:0] prev_val2;
  state_t     state2;

  count_seq_checker dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .prev_val(prev_val), .state(state)
  );

  count_seq_checker #(.ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .din(din), .clear(clear),
    .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2),
    .prev_val(prev_val2), .state(state2)
  );

  int compared = 0;
  int mismatched = 0;

  // ---------------- reference model ----------------
  int         m_state = 0; // 0 idle, 1 acq, 2 locked
  int         m_match = 0;
  int         m_miss  = 0;
  logic [7:0] m_prev  = 8'h00;
  int         m_cnt   = 0;
  int         m_cnt2  = 0;
  logic       m_pulse = 1'b0;

  logic [W1-1:0] exp_q[$];
  logic [W2-1:0] exp2_q[$];

  task automatic model_step(input logic e, input logic [7:0] d, input logic c, input logic r);
    logic [7:0] nxt;
    if (r) begin
      m_state = 0; m_match = 0; m_miss = 0; m_prev = 8'h00;
      m_cnt = 0; m_cnt2 = 0; m_pulse = 1'b0;
    end else begin
      m_pulse = 1'b0;
      nxt = m_prev + 8'd1;
      if (e) begin
        if (m_state == 0) begin
          m_state = 1; m_match = 0; m_miss = 0;
        end else if (m_state == 1) begin
          if (d == nxt) begin
            m_match = m_match + 1;
            if (m_match == 4) begin m_state = 2; m_match = 0; m_miss = 0; end
          end else begin
            m_match = 0;
          end
        end else begin
          if (d == nxt) begin
            m_miss = 0;
          end else begin
            m_pulse = 1'b1;
            m_miss = m_miss + 1;
            if (m_miss == 2) begin m_state = 1; m_match = 0; m_miss = 0; end
          end
        end
        m_prev = d;
      end
      if (c) begin
        m_cnt  = m_pulse ? 1 : 0;
        m_cnt2 = m_pulse ? 1 : 0;
      end else if (m_pulse) begin
        if (m_cnt < 255) m_cnt = m_cnt + 1;
        if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
      end
    end
    exp_q.push_back({m_state == 2, m_pulse, 8'(m_cnt), m_prev, 2'(m_state)});
    exp2_q.push_back({m_state == 2, m_pulse, 2'(m_cnt2), m_prev, 2'(m_state)});
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of stimulus, records the expected result, and returns
  // shortly after the active edge so callers can look at the outputs.
  task automatic drive(input logic e, input logic [7:0] d, input logic c, input logic r);
    @(negedge clk);
    en = e; din = d; clear = c; rst = r;
    model_step(e, d, c, r);
    @(posedge clk);
    #2;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    logic [W1-1:0] exp1;
    logic [W2-1:0] exp2;
    #1;
    if (exp_q.size() != 0) begin
      exp1 = exp_q.pop_front();
      compared++;
      if ({locked, err_pulse, err_count, prev_val, 2'(state)} !== exp1) begin
        mismatched++;
        $display("FAIL sb_main t=%0t actual=%h required=%h", $time,
                 {locked, err_pulse, err_count, prev_val, 2'(state)}, exp1);
      end
    end
    if (exp2_q.size() != 0) begin
      exp2 = exp2_q.pop_front();
      compared++;
      if ({locked2, err_pulse2, err_count2, prev_val2, 2'(state2)} !== exp2) begin
        mismatched++;
        $display("FAIL sb_sat2 t=%0t actual=%h required=%h", $time,
                 {locked2, err_pulse2, err_count2, prev_val2, 2'(state2)}, exp2);
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    compared++;
    if ({locked, err_pulse, err_count, prev_val, 2'(state)} !== {1'b0, 1'b0, 8'h00, 8'h00, 2'd0}) begin
      mismatched++;
      $display("FAIL reset_state actual=%h required=%h",
               {locked, err_pulse, err_count, prev_val, 2'(state)}, 20'h0);
    end
  endtask

  task automatic test_lock_acquire();
    drive(1'b1, 8'd10, 1'b0, 1'b0);
    for (int v = 11; v <= 13; v++) begin
      drive(1'b1, 8'(v), 1'b0, 1'b0);
      compared++;
      if (locked !== 1'b0) begin
        mismatched++;
        $display("FAIL acq_not_locked din=%0d actual=%b required=0", v, locked);
      end
    end
    drive(1'b1, 8'd14, 1'b0, 1'b0);
    compared++;
    if ({locked, err_count} !== {1'b1, 8'h00}) begin
      mismatched++;
      $display("FAIL acq_locked actual=%b/%0d required=1/0", locked, err_count);
    end
  endtask

  task automatic test_wrap_hold();
    for (int v = 15; v <= 253; v++) drive(1'b1, 8'(v), 1'b0, 1'b0);
    for (int v = 254; v <= 257; v++) begin
      drive(1'b1, 8'(v), 1'b0, 1'b0);
      compared++;
      if ({locked, err_pulse} !== 2'b10) begin
        mismatched++;
        $display("FAIL wrap din=%h actual=%b%b required=10", 8'(v), locked, err_pulse);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h55, 1'b0, 1'b0);
      compared++;
      if ({locked, err_pulse, prev_val} !== {2'b10, 8'h01}) begin
        mismatched++;
        $display("FAIL hold actual=%b%b/%h required=10/01", locked, err_pulse, prev_val);
      end
    end
    drive(1'b1, 8'h02, 1'b0, 1'b0);
    compared++;
    if ({locked, err_pulse, err_count} !== {2'b10, 8'h00}) begin
      mismatched++;
      $display("FAIL after_hold actual=%b%b/%0d required=10/0", locked, err_pulse, err_count);
    end
  endtask

  task automatic test_single_error();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int v = 8'h1B; v <= 8'h20; v++) drive(1'b1, 8'(v), 1'b0, 1'b0);
    drive(1'b1, 8'h30, 1'b0, 1'b0);
    compared++;
    if ({locked, err_pulse, err_count} !== {2'b11, 8'd1}) begin
      mismatched++;
      $display("FAIL single_err actual=%b%b/%0d required=11/1", locked, err_pulse, err_count);
    end
    drive(1'b1, 8'h31, 1'b0, 1'b0);
    compared++;
    if ({locked, err_pulse, err_count} !== {2'b10, 8'd1}) begin
      mismatched++;
      $display("FAIL single_err_after actual=%b%b/%0d required=10/1", locked, err_pulse, err_count);
    end
  endtask

  task automatic test_loss_of_lock();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int v = 0; v <= 5; v++) drive(1'b1, 8'(v), 1'b0, 1'b0);
    drive(1'b1, 8'h05, 1'b0, 1'b0);
    compared++;
    if ({locked, err_pulse, err_count} !== {2'b11, 8'd1}) begin
      mismatched++;
      $display("FAIL stuck_1 actual=%b%b/%0d required=11/1", locked, err_pulse, err_count);
    end
    drive(1'b1, 8'h05, 1'b0, 1'b0);
    compared++;
    if ({locked, err_pulse, err_count, 2'(state)} !== {2'b01, 8'd2, 2'd1}) begin
      mismatched++;
      $display("FAIL stuck_2 actual=%b%b/%0d/%0d required=01/2/1", locked, err_pulse, err_count, state);
    end
    for (int v = 6; v <= 9; v++) drive(1'b1, 8'(v), 1'b0, 1'b0);
    compared++;
    if ({locked, err_count} !== {1'b1, 8'd2}) begin
      mismatched++;
      $display("FAIL relock actual=%b/%0d required=1/2", locked, err_count);
    end
  endtask

  task automatic test_clear_collision();
    drive(1'b1, 8'h20, 1'b0, 1'b0);
    drive(1'b1, 8'h21, 1'b0, 1'b0);
    compared++;
    if (err_count !== 8'd3) begin
      mismatched++;
      $display("FAIL pre_clear actual=%0d required=3", err_count);
    end
    drive(1'b1, 8'h40, 1'b1, 1'b0);
    compared++;
    if ({err_pulse, err_count} !== {1'b1, 8'd1}) begin
      mismatched++;
      $display("FAIL clear_collide actual=%b/%0d required=1/1", err_pulse, err_count);
    end
    drive(1'b1, 8'h41, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    compared++;
    if ({locked, err_count, prev_val} !== {1'b1, 8'd0, 8'h41}) begin
      mismatched++;
      $display("FAIL clear_alone actual=%b/%0d/%h required=1/0/41", locked, err_count, prev_val);
    end
  endtask

  task automatic test_saturation();
    int pulses;
    pulses = 0;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int v = 0; v <= 4; v++) drive(1'b1, 8'(v), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h50 + 16 * i), 1'b0, 1'b0);
      if (err_pulse2 === 1'b1) pulses++;
      drive(1'b1, 8'(8'h51 + 16 * i), 1'b0, 1'b0);
    end
    compared++;
    if ({pulses, err_count2, err_count, locked2} !== {32'd5, 2'd3, 8'd5, 1'b1}) begin
      mismatched++;
      $display("FAIL saturate actual=pulses %0d cnt2 %0d cnt %0d lk %b required=5/3/5/1",
               pulses, err_count2, err_count, locked2);
    end
  endtask

  task automatic test_reset_mid_run();
    drive(1'b1, 8'h80, 1'b0, 1'b0);
    drive(1'b1, 8'h81, 1'b0, 1'b0);
    drive(1'b1, 8'h88, 1'b0, 1'b0);
    drive(1'b1, 8'h89, 1'b0, 1'b0);
    compared++;
    if ({locked, err_count} !== {1'b1, 8'd7}) begin
      mismatched++;
      $display("FAIL pre_reset actual=%b/%0d required=1/7", locked, err_count);
    end
    drive(1'b1, 8'h8A, 1'b0, 1'b1);
    compared++;
    if ({locked, err_pulse, err_count, prev_val, 2'(state)} !== 20'h0) begin
      mismatched++;
      $display("FAIL mid_reset actual=%h required=00000",
               {locked, err_pulse, err_count, prev_val, 2'(state)});
    end
    drive(1'b1, 8'h90, 1'b0, 1'b0);
    compared++;
    if ({err_pulse, 2'(state), prev_val} !== {1'b0, 2'd1, 8'h90}) begin
      mismatched++;
      $display("FAIL first_after_reset actual=%b/%0d/%h required=0/1/90", err_pulse, state, prev_val);
    end
    for (int v = 8'h91; v <= 8'h94; v++) drive(1'b1, 8'(v), 1'b0, 1'b0);
    compared++;
    if ({locked, err_count} !== {1'b1, 8'd0}) begin
      mismatched++;
      $display("FAIL relock_after_reset actual=%b/%0d required=1/0", locked, err_count);
    end
  endtask

  task automatic test_random();
    logic [7:0] cur;
    logic       e, c, r, glitch;
    logic [7:0] d;
    cur = prev_val;
    for (int i = 0; i < 400; i++) begin
      e      = ($urandom_range(0, 3) != 0);
      glitch = ($urandom_range(0, 11) == 0);
      c      = ($urandom_range(0, 31) == 0);
      r      = ($urandom_range(0, 99) == 0);
      d      = glitch ? 8'($urandom_range(0, 255)) : cur + 8'd1;
      if (e) cur = d;
      if (r) cur = 8'h00;
      drive(e, d, c, r);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_lock_acquire();
    test_wrap_hold();
    test_single_error();
    test_loss_of_lock();
    test_clear_collision();
    test_saturation();
    test_reset_mid_run();
    test_random();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    compared++;
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      mismatched++;
      $display("FAIL sb_drain actual=%0d/%0d required=0/0", exp_q.size(), exp2_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
